rf_wb_arbiter: RTL

//  Single owner of the register-file write port (rf_we/rf_waddr/rf_wdata), feeding regs from the write side.

---
 rtl/rf_wb_arbiter_pkg.sv | 15 +
 rtl/rf_wb_arbiter_if.sv | 13 +
 rtl/rf_wb_arbiter_wb_fifo.sv | 43 ++++
 rtl/rf_wb_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and default sizing for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned RfAddrW     = 5;
    localparam int unsigned RfDataW     = 32;
    localparam int unsigned RfBufDepth  = 2;
    localparam int unsigned RfStarveMax = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StForce = 2'd2
    } wba_state_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Long-latency result channel: valid/ready handshake carrying destination and data.
interface rf_wb_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              lw_valid;
    logic              lw_ready;
    logic [ADDR_W-1:0] lw_addr;
    logic [DATA_W-1:0] lw_data;

    modport master (output lw_valid, output lw_addr, output lw_data, input lw_ready);
    modport slave  (input lw_valid, input lw_addr, input lw_data, output lw_ready);
endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Small circular queue for long-latency results; DEPTH must be a power of 2.
module rf_wb_arbiter_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port owner: pipeline writeback, queued long-latency results, busy scoreboard.
// Define RF_WB_BYPASS_EN to let a long result write straight through when the port is idle.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = RfAddrW,
    parameter int unsigned DATA_W     = RfDataW,
    parameter int unsigned BUF_DEPTH  = RfBufDepth,
    parameter int unsigned STARVE_MAX = RfStarveMax
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              stall_req,
    rf_wb_arbiter_if.slave    lw,
    input  logic              alloc_we,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              dchk,
    input  logic [ADDR_W-1:0] daddr,
    output logic              hazard,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam int unsigned CntW    = $clog2(BUF_DEPTH + 1);
    localparam int unsigned StW     = $clog2(STARVE_MAX + 1);

    wba_state_e          state_q;
    logic [StW-1:0]      starve_q, starve_inc;
    logic                stall_q, ready_q;
    logic [NumRegs-1:0]  busy_q, busy_d;
    logic                push, pop, wb_commit, bypass, full, empty;
    logic [CntW-1:0]     count, count_next;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;

    rf_wb_arbiter_wb_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({lw.lw_addr, lw.lw_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head_addr  = head[DATA_W +: ADDR_W];
    assign head_data  = head[DATA_W-1:0];
    assign stall_req  = stall_q;
    assign lw.lw_ready = ready_q;

    // stall_q is high exactly in FORCE, so the pipeline never beats a forced head.
    assign wb_commit = wb_we && !stall_q;

`ifdef RF_WB_BYPASS_EN
    assign bypass = (count == '0) && !wb_we && (state_q == StIdle) && lw.lw_valid &&
                    (lw.lw_addr != '0);
`else
    assign bypass = 1'b0;
`endif

    assign push       = lw.lw_valid && ready_q && !bypass;
    assign pop        = !empty && !wb_commit;
    assign starve_inc = starve_q + StW'(1);

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + CntW'(1);
        else if (pop && !push) count_next = count - CntW'(1);
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = head_addr;
        rf_wdata = head_data;
        if (wb_commit) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (bypass) begin
            rf_we    = 1'b1;
            rf_waddr = lw.lw_addr;
            rf_wdata = lw.lw_data;
        end else if (pop) begin
            rf_we = (head_addr != '0);
        end
        rf_we = rf_we && rst_n;
    end

    // Set after clear so a same-cycle allocate of the retiring register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (pop)    busy_d[head_addr]  = 1'b0;
        if (bypass) busy_d[lw.lw_addr] = 1'b0;
        if (alloc_we && (alloc_addr != '0)) busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign hazard = (re1 && busy_q[raddr1]) || (re2 && busy_q[raddr2]) || (dchk && busy_q[daddr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            starve_q <= '0;
            stall_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= (count_next < CntW'(BUF_DEPTH));
            stall_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    starve_q <= '0;
                    if (push) state_q <= StWait;
                end
                StWait: begin
                    if (pop) begin
                        starve_q <= '0;
                        if (count_next == '0) state_q <= StIdle;
                    end else if (starve_inc == StW'(STARVE_MAX)) begin
                        starve_q <= '0;
                        stall_q  <= 1'b1;
                        state_q  <= StForce;
                    end else begin
                        starve_q <= starve_inc;
                    end
                end
                StForce: begin
                    starve_q <= '0;
                    state_q  <= (count_next != '0) ? StWait : StIdle;
                end
                default: begin
                    starve_q <= '0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

    assert property (@(posedge clk) disable iff (!rst_n)
        (alloc_we && (alloc_addr != '0)) |->
        (!busy_q[alloc_addr] || (pop && (head_addr == alloc_addr)) ||
         (bypass && (lw.lw_addr == alloc_addr))));
endmodule
